// File: rtl/seven_seg_scan_decoder.sv
// Receive-side decoder for a multiplexed 4-digit seven-segment bus: waits for each
// digit dwell to settle, decodes the segments to a nibble and assembles 16-bit frames.
module seven_seg_scan_decoder #(
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic        Clk,
    input  logic        reset,
    input  logic [3:0]  AN_SEL,
    input  logic [6:0]  seven_seg_out,
    output logic [15:0] value,
    output logic        value_valid,
    output logic [3:0]  blank_mask,
    output logic        seg_err,
    output logic        timeout
);

    localparam int SW = $clog2(SETTLE_CYCLES + 2);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [SW-1:0] SETTLE_V = SW'(SETTLE_CYCLES);
    localparam logic [SW-1:0] STAB_SAT = SW'(SETTLE_CYCLES + 1);
    localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TMR_MAX  = TW'(TIMEOUT_CYCLES);

    typedef enum logic {COLLECT, EMIT} state_t;

    // {bad, blank, nibble}
    function automatic logic [5:0] decode_seg(input logic [6:0] s);
        case (s)
            7'h40: decode_seg = 6'h00;
            7'h79: decode_seg = 6'h01;
            7'h24: decode_seg = 6'h02;
            7'h30: decode_seg = 6'h03;
            7'h19: decode_seg = 6'h04;
            7'h12: decode_seg = 6'h05;
            7'h02: decode_seg = 6'h06;
            7'h78: decode_seg = 6'h07;
            7'h00: decode_seg = 6'h08;
            7'h10: decode_seg = 6'h09;
            7'h08: decode_seg = 6'h0A;
            7'h03: decode_seg = 6'h0B;
            7'h46: decode_seg = 6'h0C;
            7'h21: decode_seg = 6'h0D;
            7'h06: decode_seg = 6'h0E;
            7'h0E: decode_seg = 6'h0F;
            7'h7F: decode_seg = 6'h10;
            default: decode_seg = 6'h20;
        endcase
    endfunction

    logic [3:0]      an_p0, an_p1;
    logic [6:0]      seg_p0, seg_p1;
    logic [SW-1:0]   stab_cnt, stab_next;
    logic [TW-1:0]   tmr;
    logic [3:0][3:0] shadow;
    logic [3:0]      seen, blank_flags, hit;
    logic            bad, sample_ok, capture, to_fire;
    logic [5:0]      dec;
    state_t          state, state_d;

    assign hit       = ~an_p0;
    assign sample_ok = $onehot(hit);
    assign dec       = decode_seg(seg_p0);

    // Counter restarts at 1 on any sample change and parks one above the
    // threshold, so each dwell captures exactly once.
    always_comb begin
        stab_next = '0;
        if (sample_ok) begin
            if ({an_p0, seg_p0} != {an_p1, seg_p1})
                stab_next = SW'(1);
            else if (stab_cnt == STAB_SAT)
                stab_next = stab_cnt;
            else
                stab_next = stab_cnt + 1'b1;
        end
    end

    assign capture = sample_ok && (stab_next == SETTLE_V);
    assign to_fire = !capture && (state != EMIT) && (tmr == TMR_LAST) && (seen != 4'h0);

    always_comb begin
        state_d = state;
        case (state)
            COLLECT: if (capture && ((seen | hit) == 4'hF)) state_d = EMIT;
            EMIT:    state_d = COLLECT;
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            an_p0       <= '0;
            an_p1       <= '0;
            seg_p0      <= '0;
            seg_p1      <= '0;
            stab_cnt    <= '0;
            tmr         <= '0;
            shadow      <= '0;
            seen        <= '0;
            blank_flags <= '0;
            bad         <= 1'b0;
            value       <= '0;
            value_valid <= 1'b0;
            blank_mask  <= '0;
            seg_err     <= 1'b0;
            timeout     <= 1'b0;
            state       <= COLLECT;
        end else begin
            an_p0       <= AN_SEL;
            seg_p0      <= seven_seg_out;
            an_p1       <= an_p0;
            seg_p1      <= seg_p0;
            stab_cnt    <= stab_next;
            state       <= state_d;
            value_valid <= 1'b0;
            timeout     <= 1'b0;

            if (capture || state == EMIT)
                tmr <= '0;
            else if (tmr != TMR_MAX)
                tmr <= tmr + 1'b1;

            if (state == EMIT) begin
                value       <= shadow;
                blank_mask  <= blank_flags;
                seg_err     <= bad;
                value_valid <= 1'b1;
                seen        <= '0;
                bad         <= 1'b0;
            end else if (to_fire) begin
                timeout     <= 1'b1;
                seen        <= '0;
                bad         <= 1'b0;
                blank_flags <= '0;
            end

            // A capture landing in the EMIT cycle starts the next frame.
            if (capture) begin
                for (int i = 0; i < 4; i++) begin
                    if (hit[i]) begin
                        shadow[i]      <= dec[3:0];
                        blank_flags[i] <= dec[4];
                    end
                end
                seen <= ((state == EMIT) ? 4'h0 : seen) | hit;
                bad  <= ((state == EMIT) ? 1'b0 : bad) | dec[5];
            end
        end
    end

endmodule
